// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/data memory handshakes.
// master = controller side, slave = memory side.
interface multicycle_ctrl_if;
  logic       imem_req;
  logic       imem_ack;
  logic [8:0] instr;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  instr,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output instr,
    output dmem_ack
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/wb sequencer for 9-bit instrs.
// Optional ack timeout: define MULTICYCLE_CTRL_TIMEOUT_EN.
module multicycle_ctrl #(
  parameter int RETIRE_W       = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  multicycle_ctrl_if.master   mem,
  input  logic                zero,
  output logic [1:0]          ALUOp,
  output logic [3:0]          FunctBit,
  output logic                ir_load,
  output logic                reg_we,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                done,
  output logic                err,
  output logic [RETIRE_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } st_t;

  st_t        st;
  st_t        nxt;
  logic [2:0] opnd;
  logic       tmo;
  logic       is_halt;

  assign is_halt = {ALUOp, FunctBit, opnd} == 9'h1FF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      ALUOp      <= '0;
      FunctBit   <= '0;
      opnd       <= '0;
      retire_cnt <= '0;
    end else begin
      st <= nxt;
      if (ir_load)
        {ALUOp, FunctBit, opnd} <= mem.instr;
      if (pc_inc | pc_load)
        retire_cnt <= retire_cnt + RETIRE_W'(1);
    end
  end

  always_comb begin
    nxt          = st;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_load      = 1'b0;
    reg_we       = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    done         = 1'b0;
    unique case (st)
      IDLE: if (start) nxt = FETCH;
      FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ack) begin
          ir_load = 1'b1;
          nxt     = DECODE;
        end else if (tmo) begin
          nxt = HALT;
        end
      end
      DECODE: nxt = is_halt ? HALT : EXEC;
      EXEC: begin
        unique case (1'b1)
          !ALUOp[1]: nxt = WB;
          ALUOp == 2'b10 && !FunctBit[3]: begin
            pc_load = zero;
            pc_inc  = !zero;
            nxt     = FETCH;
          end
          ALUOp == 2'b10 && FunctBit[3]: begin
            pc_load = 1'b1;
            nxt     = FETCH;
          end
          ALUOp == 2'b11 && FunctBit[3:1] == 3'b000: nxt = MEM;
          default: begin
            pc_inc = 1'b1;
            nxt    = FETCH;
          end
        endcase
      end
      MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = FunctBit[0];
        if (mem.dmem_ack) begin
          if (FunctBit[0]) begin
            pc_inc = 1'b1;
            nxt    = FETCH;
          end else begin
            nxt = WB;
          end
        end else if (tmo) begin
          nxt = HALT;
        end
      end
      WB: begin
        reg_we = 1'b1;
        pc_inc = 1'b1;
        nxt    = FETCH;
      end
      HALT: begin
        done = 1'b1;
        if (start) nxt = FETCH;
      end
      default: nxt = IDLE;
    endcase
  end

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] tcnt;
  logic          miss;
  logic          err_q;

  assign miss = (st == FETCH && !mem.imem_ack) ||
                (st == MEM && !mem.dmem_ack);
  assign tmo  = tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign err  = err_q;

  // tcnt counts unanswered request cycles of the current wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (nxt != st)
        tcnt <= '0;
      else if (miss)
        tcnt <= tcnt + TW'(1);
      if (miss && tmo)
        err_q <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed vector table plus hand-written
// halt, wait, and async-reset sequences.
module tb_multicycle_ctrl;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        zero;
  logic [1:0]  ALUOp;
  logic [3:0]  FunctBit;
  logic        ir_load;
  logic        reg_we;
  logic        pc_inc;
  logic        pc_load;
  logic        done;
  logic        err;
  logic [15:0] retire_cnt;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;
  int ohv = 0;

  multicycle_ctrl_if mem();

  multicycle_ctrl #(
    .RETIRE_W(16),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .mem(mem),
    .zero(zero),
    .ALUOp(ALUOp),
    .FunctBit(FunctBit),
    .ir_load(ir_load),
    .reg_we(reg_we),
    .pc_inc(pc_inc),
    .pc_load(pc_load),
    .done(done),
    .err(err),
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] instr;
    logic       zero;
    int         dly;
    int         cyc;
    int         we;
    int         inc;
    int         ld;
    int         dreq;
    logic       dwe;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    vt[0] = '{9'b00_0100_011, 1'b0, 0, 4, 1, 1, 0, 0, 1'b0};
    vt[1] = '{9'b10_0000_000, 1'b1, 0, 3, 0, 0, 1, 0, 1'b0};
    vt[2] = '{9'b10_0000_000, 1'b0, 0, 3, 0, 1, 0, 0, 1'b0};
    vt[3] = '{9'b11_0000_010, 1'b0, 3, 8, 1, 1, 0, 4, 1'b0};
    vt[4] = '{9'b11_0001_010, 1'b0, 0, 4, 0, 1, 0, 1, 1'b1};
    vt[5] = '{9'b01_1010_101, 1'b0, 0, 4, 1, 1, 0, 0, 1'b0};
    vt[6] = '{9'b10_1000_000, 1'b0, 0, 3, 0, 0, 1, 0, 1'b0};
    vt[7] = '{9'b11_0101_000, 1'b0, 0, 3, 0, 1, 0, 0, 1'b0};
    vt[8] = '{9'b11_0001_010, 1'b1, 2, 6, 0, 1, 0, 3, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    zero = 1'b0;
    mem.imem_ack = 1'b0;
    mem.dmem_ack = 1'b0;
    mem.instr = 9'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs",
        {mem.imem_req, mem.dmem_req, mem.dmem_we, ir_load,
         reg_we, pc_inc, pc_load, done, err, ALUOp, FunctBit},
        32'h0);
    chk("reset_retire", retire_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_no_req", mem.imem_req, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start_fetch", mem.imem_req, 1);

    for (int i = 0; i < 9; i++) begin
      int c, we, inc, ld, dreq, dwe, k;
      logic [1:0] aop;
      logic [3:0] fb;
      bit fin;
      c = 0; we = 0; inc = 0; ld = 0;
      dreq = 0; dwe = 0; k = 0; fin = 0;
      aop = 2'b0; fb = 4'b0;
      zero = vt[i].zero;
      while (!fin && c < 60) begin
        @(negedge clk);
        mem.imem_ack = (c == 0);
        mem.instr = (c == 0) ? vt[i].instr : 9'h0AA;
        mem.dmem_ack = mem.dmem_req ? (k == vt[i].dly)
                                    : (c == 2);
        #1;
        if (c > 0 && mem.imem_req) begin
          fin = 1;
        end else begin
          we += int'(reg_we);
          inc += int'(pc_inc);
          ld += int'(pc_load);
          if (int'(ir_load) + int'(reg_we) + int'(pc_load) > 1 ||
              (pc_inc && pc_load))
            ohv++;
          if (mem.dmem_req) begin
            dreq++;
            dwe += int'(mem.dmem_we);
            k++;
          end
          if (c == 1) begin
            aop = ALUOp;
            fb = FunctBit;
          end
          c++;
        end
      end
      mem.imem_ack = 1'b0;
      mem.dmem_ack = 1'b0;
      exp_ret += vt[i].inc + vt[i].ld;
      chk($sformatf("v%0d_cycles", i), c, vt[i].cyc);
      chk($sformatf("v%0d_reg_we", i), we, vt[i].we);
      chk($sformatf("v%0d_pc_inc", i), inc, vt[i].inc);
      chk($sformatf("v%0d_pc_load", i), ld, vt[i].ld);
      chk($sformatf("v%0d_dmem_req", i), dreq, vt[i].dreq);
      chk($sformatf("v%0d_dmem_we", i), dwe,
          vt[i].dwe ? vt[i].dreq : 0);
      chk($sformatf("v%0d_aluop", i), aop, vt[i].instr[8:7]);
      chk($sformatf("v%0d_funct", i), fb, vt[i].instr[6:3]);
      chk($sformatf("v%0d_retire", i), retire_cnt, exp_ret);
    end
    chk("onehot_strobes", ohv, 0);

    begin
      int rq;
      @(negedge clk);
      mem.imem_ack = 1'b1;
      mem.instr = 9'h1FF;
      @(negedge clk);
      mem.imem_ack = 1'b0;
      @(negedge clk);
      #1;
      chk("halt_done", done, 1);
      rq = 0;
      repeat (5) begin
        @(negedge clk);
        start = 1'b0;
        mem.imem_ack = 1'b1;
        #1;
        rq += int'(mem.imem_req);
        rq += int'(ir_load);
      end
      mem.imem_ack = 1'b0;
      chk("halt_no_req", rq, 0);
      chk("halt_retire", retire_cnt, exp_ret);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("resume_fetch", mem.imem_req, 1);
      chk("resume_not_done", done, 0);
    end

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    repeat (20) @(negedge clk);
    #1;
    chk("tmo_err", err, 1);
    chk("tmo_done", done, 1);
    chk("tmo_req_drop", mem.imem_req, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
`else
    begin
      int rc;
      rc = 0;
      repeat (40) begin
        @(negedge clk);
        #1;
        rc += int'(mem.imem_req);
      end
      chk("wait_unbounded", rc, 40);
      chk("no_err", err, 0);
    end
`endif

    begin
      bit seen;
      seen = 0;
      @(negedge clk);
      mem.imem_ack = 1'b1;
      mem.instr = 9'b11_0000_010;
      @(negedge clk);
      mem.imem_ack = 1'b0;
      for (int j = 0; j < 10 && !seen; j++) begin
        @(negedge clk);
        #1;
        if (mem.dmem_req) seen = 1;
      end
      chk("mem_reached", seen, 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_reqs", {mem.imem_req, mem.dmem_req, mem.dmem_we}, 0);
      chk("arst_outs",
          {ir_load, reg_we, pc_inc, pc_load, done, err,
           ALUOp, FunctBit}, 0);
      chk("arst_retire", retire_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_idle",
          {mem.imem_req, mem.dmem_req, reg_we, pc_inc}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
